rr_code_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 3-bit select code among 7 requesters.

---
 rtl/rr_code_arbiter_pkg.sv | 14 +
 rtl/rr_code_arbiter_code_to_onehot.sv | 20 ++
 rtl/rr_code_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_code_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_code_arbiter_pkg.sv
// Shared types and constants for the round-robin grant-code arbiter.
//   arb_state_e : arbiter FSM states (idle, granting, break-before-make gap)
//   CodeNone    : grant code value meaning "no requester granted"
package rr_code_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } arb_state_e;

  localparam int unsigned CodeNone = 0;

endpackage

// File: rtl/rr_code_arbiter_code_to_onehot.sv
// Decodes a grant code into one-hot enables for the shared resource.
// Ports:
//   code   in  CODE_W  grant code, 0 = none, 1..N = requester
//   onehot out N       bit i set iff code == i+1; all zero for code 0
module rr_code_arbiter_code_to_onehot #(
  parameter int unsigned CODE_W = 3,
  localparam int unsigned N     = (1 << CODE_W) - 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [N-1:0]      onehot
);

  always_comb begin
    onehot = '0;
    if (code != '0) begin
      onehot = N'(1) << (code - 1'b1);
    end
  end

endmodule

// File: rtl/rr_code_arbiter.sv
// Round-robin arbiter sharing one grant code among N = 2**CODE_W-1 requesters.
// A grant is held while its owner keeps requesting, up to MAX_HOLD cycles,
// and every hand-over passes through one dead cycle with code 0.
// Ports:
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   req          in   N       level requests; req[i] asks for code i+1
//   grant_code   out  CODE_W  registered grant code, 0 = no grant
//   grant_onehot out  N       decoded grant_code
//   busy         out  1       high while a grant is active
//   timeout      out  1       one-cycle pulse when a grant hits the hold limit
module rr_code_arbiter
  import rr_code_arbiter_pkg::*;
#(
  parameter int unsigned CODE_W   = 3,
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned HOLD_W   = 8,
  localparam int unsigned N       = (1 << CODE_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  output logic [CODE_W-1:0] grant_code,
  output logic [N-1:0]      grant_onehot,
  output logic              busy,
  output logic              timeout
);

  arb_state_e        state_q, state_d;
  logic [CODE_W-1:0] grant_code_q, grant_code_d;
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CODE_W-1:0] pick;
  logic              owner_req;

  // First requesting code after `last`, wrapping N -> 1; `last` itself is
  // searched last so a sole requester can win again.
  function automatic logic [CODE_W-1:0] rr_pick(input logic [N-1:0]      r,
                                                input logic [CODE_W-1:0] last);
    logic [CODE_W-1:0] sel;
    logic              found;
    int unsigned       c;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = 32'(last) + k;
      if (c > N) c = c - N;
      if (!found && r[CODE_W'(c - 1)]) begin
        sel   = CODE_W'(c);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  rr_code_arbiter_code_to_onehot #(
    .CODE_W(CODE_W)
  ) u_decode (
    .code  (grant_code_q),
    .onehot(grant_onehot)
  );

  // Owner's request, selected through the decoded enables (no code-0 index).
  assign owner_req = |(req & grant_onehot);
  assign pick      = rr_pick(req, last_code_q);

  always_comb begin
    state_d      = state_q;
    grant_code_d = grant_code_q;
    last_code_d  = last_code_q;
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      StIdle, StGap: begin
        if (|req) begin
          state_d      = StGrant;
          grant_code_d = pick;
          last_code_d  = pick;
          hold_cnt_d   = '0;
        end else begin
          state_d      = StIdle;
          grant_code_d = CODE_W'(CodeNone);
        end
      end
      StGrant: begin
        if (!owner_req) begin
          // Normal release wins over a coincident hold limit: no timeout.
          state_d      = StGap;
          grant_code_d = CODE_W'(CodeNone);
          hold_cnt_d   = '0;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d      = StGap;
          grant_code_d = CODE_W'(CodeNone);
          hold_cnt_d   = '0;
          timeout_d    = 1'b1;
        end else begin
          hold_cnt_d   = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = StIdle;
        grant_code_d = CODE_W'(CodeNone);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_code_q <= CODE_W'(CodeNone);
      last_code_q  <= CODE_W'(N);
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_code_q <= grant_code_d;
      last_code_q  <= last_code_d;
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant_code = grant_code_q;
  assign busy       = (state_q == StGrant);
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_code_arbiter.sv
module tb_rr_code_arbiter;

  logic       clk;
  logic       rst_n;
  logic [6:0] req;

  logic [2:0] code4, code3;
  logic [6:0] oh4, oh3;
  logic       busy4, busy3, to4, to3;

  typedef struct {
    logic [2:0] c4;
    logic       t4;
    logic [2:0] c3;
    logic       t3;
    bit         k3;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  rr_code_arbiter #(
    .CODE_W  (3),
    .MAX_HOLD(4),
    .HOLD_W  (8)
  ) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_code  (code4),
    .grant_onehot(oh4),
    .busy        (busy4),
    .timeout     (to4)
  );

  rr_code_arbiter #(
    .CODE_W  (3),
    .MAX_HOLD(3),
    .HOLD_W  (8)
  ) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_code  (code3),
    .grant_onehot(oh3),
    .busy        (busy3),
    .timeout     (to3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] onehot_of(input logic [2:0] c);
    logic [6:0] v;
    v = '0;
    if (c != 3'd0) v[c - 3'd1] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each cycle with a pending expectation is compared after the edge.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("code4", int'(code4), int'(e.c4));
      check("onehot4", int'(oh4), int'(onehot_of(e.c4)));
      check("busy4", int'(busy4), int'(e.c4 != 3'd0));
      check("timeout4", int'(to4), int'(e.t4));
      if (e.k3) begin
        check("code3", int'(code3), int'(e.c3));
        check("onehot3", int'(oh3), int'(onehot_of(e.c3)));
        check("busy3", int'(busy3), int'(e.c3 != 3'd0));
        check("timeout3", int'(to3), int'(e.t3));
      end
    end
  end

  // Called at a negedge: drive req, queue the outputs expected after the
  // coming rising edge, then move to the next negedge.
  task automatic step(input logic [6:0] r, input logic [2:0] c4, input logic t4,
                      input logic [2:0] c3, input logic t3, input bit k3);
    exp_t x;
    req  = r;
    x.c4 = c4;
    x.t4 = t4;
    x.c3 = c3;
    x.t3 = t3;
    x.k3 = k3;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic step4(input logic [6:0] r, input logic [2:0] c, input logic t);
    step(r, c, t, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_code4"}, int'(code4), 0);
    check({tag, "_onehot4"}, int'(oh4), 0);
    check({tag, "_busy4"}, int'(busy4), 0);
    check({tag, "_timeout4"}, int'(to4), 0);
    check({tag, "_code3"}, int'(code3), 0);
    check({tag, "_busy3"}, int'(busy3), 0);
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic apply_reset(input logic [6:0] r);
    #1;
    rst_n = 1'b0;
    req   = r;
    #1;
    zero_checks("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);

    // Reset with all requests high, then full rotation with hold limit 4.
    apply_reset(7'h7F);
    for (int c = 1; c <= 7; c++) begin
      for (int k = 0; k < 4; k++) step4(7'h7F, 3'(c), 1'b0);
      step4(7'h7F, 3'd0, 1'b1);
    end
    step4(7'h7F, 3'd1, 1'b0);

    // Early release of owner 1, then owner 3 after one gap cycle.
    apply_reset(7'h05);
    step4(7'h05, 3'd1, 1'b0);
    step4(7'h05, 3'd1, 1'b0);
    step4(7'h04, 3'd0, 1'b0);
    step4(7'h04, 3'd3, 1'b0);
    step4(7'h04, 3'd3, 1'b0);
    step4(7'h00, 3'd0, 1'b0);
    step4(7'h00, 3'd0, 1'b0);

    // Owner drops its request on the hold-limit edge: plain release.
    for (int k = 0; k < 4; k++) step4(7'h04, 3'd3, 1'b0);
    step4(7'h00, 3'd0, 1'b0);
    step4(7'h00, 3'd0, 1'b0);

    // Sole requester 7 on both hold limits.
    apply_reset(7'h40);
    step(7'h40, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1);
    step(7'h40, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1);
    step(7'h40, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1);
    step(7'h40, 3'd7, 1'b0, 3'd0, 1'b1, 1'b1);
    step(7'h40, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1);
    step(7'h40, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1);
    step(7'h40, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1);
    step(7'h40, 3'd7, 1'b0, 3'd0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a grant to code 5.
    apply_reset(7'h10);
    step4(7'h10, 3'd5, 1'b0);
    step4(7'h10, 3'd5, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    zero_checks("async");
    req = 7'h7F;
    @(negedge clk);
    rst_n = 1'b1;
    step4(7'h7F, 3'd1, 1'b0);
    step4(7'h7F, 3'd1, 1'b0);

    @(negedge clk);
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
